// File: rtl/nios2_sysid_pkg.sv
// rtl/nios2_sysid_pkg.sv - shared types and constants for the sysid access controller
package nios2_sysid_pkg;

    localparam int SYSID_DW = 32;

    localparam logic SYSID_ADDR_ID = 1'b0;
    localparam logic SYSID_ADDR_TS = 1'b1;

    typedef enum logic [1:0] {
        CHK_ID = 2'd0,
        CHK_TS = 2'd1,
        READY  = 2'd2
    } sysid_state_t;

endpackage

// File: rtl/nios2_sysid_ctrl_if.sv
// rtl/nios2_sysid_ctrl_if.sv - requester and sysid slave signals of the access controller
interface nios2_sysid_ctrl_if;
    import nios2_sysid_pkg::*;

    logic                m0_read;
    logic                m0_address;
    logic                m0_waitrequest;
    logic [SYSID_DW-1:0] m0_readdata;
    logic                m0_readdatavalid;

    logic                m1_read;
    logic                m1_address;
    logic                m1_waitrequest;
    logic [SYSID_DW-1:0] m1_readdata;
    logic                m1_readdatavalid;

    logic                sysid_address;
    logic [SYSID_DW-1:0] sysid_readdata;

    // Controller side
    modport slave (
        input  m0_read, m0_address, m1_read, m1_address, sysid_readdata,
        output m0_waitrequest, m0_readdata, m0_readdatavalid,
        output m1_waitrequest, m1_readdata, m1_readdatavalid,
        output sysid_address
    );

    // Requesters and sysid slave side
    modport master (
        output m0_read, m0_address, m1_read, m1_address, sysid_readdata,
        input  m0_waitrequest, m0_readdata, m0_readdatavalid,
        input  m1_waitrequest, m1_readdata, m1_readdatavalid,
        input  sysid_address
    );

endinterface

// File: rtl/nios2_rr_arb2.sv
// rtl/nios2_rr_arb2.sv - two-input round-robin arbiter with a last-grant pointer
module nios2_rr_arb2 (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant
);

    // last_q = 1 means requester 1 was granted last, so requester 0 wins the next tie
    logic last_q;
    logic last_d;

    // Grant decision and pointer update; pointer only moves when something is granted
    always_comb begin
        grant  = 2'b00;
        last_d = last_q;
        if (advance) begin
            case (req)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = last_q ? 2'b01 : 2'b10;
                default: grant = 2'b00;
            endcase
        end
        if (grant[0]) begin
            last_d = 1'b0;
        end else if (grant[1]) begin
            last_d = 1'b1;
        end
    end

    // Pointer register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/nios2_sysid_ctrl.sv
// rtl/nios2_sysid_ctrl.sv - arbitrated sysid access with boot self-check (SYSID_BOOT_CHECK_EN)
module nios2_sysid_ctrl
    import nios2_sysid_pkg::*;
#(
    parameter logic [SYSID_DW-1:0] EXPECTED_ID = 32'h0000_0000,
    parameter logic [SYSID_DW-1:0] EXPECTED_TS = 32'd1588632594
) (
    input  logic                     clock,
    input  logic                     reset,
    nios2_sysid_ctrl_if.slave        bus,
    output logic                     check_done,
    output logic                     id_ok,
    output logic                     id_mismatch
);

`ifdef SYSID_BOOT_CHECK_EN
    localparam sysid_state_t BOOT_STATE = CHK_ID;
    localparam logic         BOOT_FLAG  = 1'b0;
`else
    localparam sysid_state_t BOOT_STATE = READY;
    localparam logic         BOOT_FLAG  = 1'b1;
`endif

    sysid_state_t        state_q, state_d;
    logic                mismatch_q, mismatch_d;
    logic                check_done_q, check_done_d;
    logic                id_ok_q, id_ok_d;
    logic                id_mismatch_q, id_mismatch_d;
    logic                rdv0_q, rdv0_d;
    logic                rdv1_q, rdv1_d;
    logic [SYSID_DW-1:0] rd0_q, rd0_d;
    logic [SYSID_DW-1:0] rd1_q, rd1_d;

    logic                advance;
    logic [1:0]          grant;
    logic                ts_mismatch;
    logic                sysid_addr;

    assign advance = (state_q == READY);

    nios2_rr_arb2 u_arb (
        .clock   (clock),
        .reset   (reset),
        .req     ({bus.m1_read, bus.m0_read}),
        .advance (advance),
        .grant   (grant)
    );

    // Boot-check sequencing, slave address mux and response capture
    always_comb begin
        state_d       = state_q;
        mismatch_d    = mismatch_q;
        check_done_d  = check_done_q;
        id_ok_d       = id_ok_q;
        id_mismatch_d = id_mismatch_q;
        ts_mismatch   = 1'b0;
        sysid_addr    = SYSID_ADDR_ID;
        rdv0_d        = grant[0];
        rdv1_d        = grant[1];
        rd0_d         = grant[0] ? bus.sysid_readdata : rd0_q;
        rd1_d         = grant[1] ? bus.sysid_readdata : rd1_q;
        case (state_q)
            CHK_ID: begin
                sysid_addr = SYSID_ADDR_ID;
                if (bus.sysid_readdata != EXPECTED_ID) begin
                    mismatch_d = 1'b1;
                end
                state_d = CHK_TS;
            end
            CHK_TS: begin
                sysid_addr    = SYSID_ADDR_TS;
                ts_mismatch   = mismatch_q | (bus.sysid_readdata != EXPECTED_TS);
                mismatch_d    = ts_mismatch;
                check_done_d  = 1'b1;
                id_ok_d       = !ts_mismatch;
                id_mismatch_d = ts_mismatch;
                state_d       = READY;
            end
            READY: begin
                if (grant[0]) begin
                    sysid_addr = bus.m0_address;
                end else if (grant[1]) begin
                    sysid_addr = bus.m1_address;
                end
            end
            default: begin
                state_d = BOOT_STATE;
            end
        endcase
    end

    // State, status and response registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= BOOT_STATE;
            mismatch_q    <= 1'b0;
            check_done_q  <= BOOT_FLAG;
            id_ok_q       <= BOOT_FLAG;
            id_mismatch_q <= 1'b0;
            rdv0_q        <= 1'b0;
            rdv1_q        <= 1'b0;
            rd0_q         <= '0;
            rd1_q         <= '0;
        end else begin
            state_q       <= state_d;
            mismatch_q    <= mismatch_d;
            check_done_q  <= check_done_d;
            id_ok_q       <= id_ok_d;
            id_mismatch_q <= id_mismatch_d;
            rdv0_q        <= rdv0_d;
            rdv1_q        <= rdv1_d;
            rd0_q         <= rd0_d;
            rd1_q         <= rd1_d;
        end
    end

    assign bus.m0_waitrequest   = !grant[0];
    assign bus.m1_waitrequest   = !grant[1];
    assign bus.m0_readdatavalid = rdv0_q;
    assign bus.m1_readdatavalid = rdv1_q;
    assign bus.m0_readdata      = rd0_q;
    assign bus.m1_readdata      = rd1_q;
    assign bus.sysid_address    = sysid_addr;
    assign check_done           = check_done_q;
    assign id_ok                = id_ok_q;
    assign id_mismatch          = id_mismatch_q;

endmodule

// File: tb/tb_nios2_sysid_ctrl.sv
// tb/tb_nios2_sysid_ctrl.sv - self-checking bench for nios2_sysid_ctrl
module tb_nios2_sysid_ctrl;

    localparam logic [31:0] EXP_ID = 32'h0000_0000;
    localparam logic [31:0] EXP_TS = 32'd1588632594;
`ifdef SYSID_BOOT_CHECK_EN
    localparam logic        RST_FLAG = 1'b0;
`else
    localparam logic        RST_FLAG = 1'b1;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic        check_done, id_ok, id_mismatch;
    logic [31:0] ts_word;

    int          checks = 0;
    int          errors = 0;

    // Reference model state
    int          last_win;
    logic [31:0] held [2];

    nios2_sysid_ctrl_if bus ();

    nios2_sysid_ctrl #(
        .EXPECTED_ID (EXP_ID),
        .EXPECTED_TS (EXP_TS)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .bus         (bus),
        .check_done  (check_done),
        .id_ok       (id_ok),
        .id_mismatch (id_mismatch)
    );

    always #5 clock = ~clock;

    // Behavioural sysid slave: two combinational words
    assign bus.sysid_readdata = bus.sysid_address ? ts_word : EXP_ID;

    function automatic logic [31:0] word_at(input logic a);
        return a ? ts_word : EXP_ID;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic r0, input logic a0, input logic r1, input logic a1);
        bus.m0_read    = r0;
        bus.m0_address = a0;
        bus.m1_read    = r1;
        bus.m1_address = a1;
    endtask

    // One READY-state cycle: predict the winner, check handshake now and the response after the edge
    task automatic cycle(input logic r0, input logic a0, input logic r1, input logic a1, output int w);
        logic exp_addr;
        drive(r0, a0, r1, a1);
        #1;
        if (r0 && r1)  w = (last_win == 1) ? 0 : 1;
        else if (r0)   w = 0;
        else if (r1)   w = 1;
        else           w = -1;
        exp_addr = (w == 0) ? a0 : (w == 1) ? a1 : 1'b0;
        chk("m0_waitrequest", 32'(bus.m0_waitrequest), 32'(w != 0));
        chk("m1_waitrequest", 32'(bus.m1_waitrequest), 32'(w != 1));
        chk("sysid_address", 32'(bus.sysid_address), 32'(exp_addr));
        @(posedge clock);
        #1;
        if (w >= 0) begin
            last_win = w;
            held[w]  = word_at(exp_addr);
        end
        chk("m0_readdatavalid", 32'(bus.m0_readdatavalid), 32'(w == 0));
        chk("m1_readdatavalid", 32'(bus.m1_readdatavalid), 32'(w == 1));
        chk("m0_readdata", bus.m0_readdata, held[0]);
        chk("m1_readdata", bus.m1_readdata, held[1]);
    endtask

    // Reset, check reset values, then run through the boot check (if built in)
    task automatic boot();
        reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        last_win = 1;
        held[0]  = '0;
        held[1]  = '0;
        @(posedge clock);
        #1;
        chk("rst check_done", 32'(check_done), 32'(RST_FLAG));
        chk("rst id_ok", 32'(id_ok), 32'(RST_FLAG));
        chk("rst id_mismatch", 32'(id_mismatch), 32'(0));
        chk("rst m0_readdatavalid", 32'(bus.m0_readdatavalid), 32'(0));
        chk("rst m1_readdatavalid", 32'(bus.m1_readdatavalid), 32'(0));
        chk("rst m0_readdata", bus.m0_readdata, 32'(0));
        chk("rst m1_readdata", bus.m1_readdata, 32'(0));
        reset = 1'b0;
`ifdef SYSID_BOOT_CHECK_EN
        bus.m0_read    = 1'b1;
        bus.m0_address = 1'b1;
        #1;
        chk("boot1 m0_waitrequest", 32'(bus.m0_waitrequest), 32'(1));
        chk("boot1 sysid_address", 32'(bus.sysid_address), 32'(0));
        @(posedge clock);
        #1;
        chk("boot2 check_done", 32'(check_done), 32'(0));
        chk("boot2 m0_waitrequest", 32'(bus.m0_waitrequest), 32'(1));
        chk("boot2 sysid_address", 32'(bus.sysid_address), 32'(1));
        @(posedge clock);
        #1;
        chk("boot check_done", 32'(check_done), 32'(1));
        chk("boot id_ok", 32'(id_ok), 32'(ts_word == EXP_TS));
        chk("boot id_mismatch", 32'(id_mismatch), 32'(ts_word != EXP_TS));
`endif
    endtask

    task automatic random_cycles(input int n);
        logic r0, a0, r1, a1;
        int   w;
        r0 = 1'b0; a0 = 1'b0; r1 = 1'b0; a1 = 1'b0; w = -1;
        for (int i = 0; i < n; i++) begin
            // a requester left waiting keeps its request unchanged
            if (!(r0 && w != 0)) begin
                r0 = 1'($urandom_range(0, 1));
                a0 = 1'($urandom_range(0, 1));
            end
            if (!(r1 && w != 1)) begin
                r1 = 1'($urandom_range(0, 1));
                a1 = 1'($urandom_range(0, 1));
            end
            cycle(r0, a0, r1, a1, w);
        end
    endtask

    initial begin
        int w;
        ts_word = EXP_TS;
        boot();
`ifdef SYSID_BOOT_CHECK_EN
        cycle(1'b1, 1'b1, 1'b0, 1'b0, w);
`else
        cycle(1'b0, 1'b0, 1'b1, 1'b1, w);
`endif
        cycle(1'b1, 1'b1, 1'b0, 1'b0, w);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, w);
        for (int i = 0; i < 6; i++) begin
            cycle(1'b1, 1'b0, 1'b1, 1'b1, w);
        end
        random_cycles(150);

        // Reset in the cycle right after an accepted read
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        @(posedge clock);
        #1;
        reset = 1'b1;
        #1;
        chk("midrst m0_readdatavalid", 32'(bus.m0_readdatavalid), 32'(0));
        chk("midrst m0_readdata", bus.m0_readdata, 32'(0));
        chk("midrst check_done", 32'(check_done), 32'(RST_FLAG));
        boot();
        cycle(1'b1, 1'b1, 1'b1, 1'b0, w);
        random_cycles(20);

`ifdef SYSID_BOOT_CHECK_EN
        ts_word = EXP_TS + 32'd1;
        boot();
        random_cycles(20);
        chk("sticky id_mismatch", 32'(id_mismatch), 32'(1));
        chk("sticky id_ok", 32'(id_ok), 32'(0));
        chk("sticky check_done", 32'(check_done), 32'(1));
        ts_word = EXP_TS;
        boot();
        random_cycles(10);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
